ocs_slot_ctrl: RTL and testbench

- Generates the slot schedule that drives the `i_slot_id` select of the OCS crossbar modules, such as the 8-port OCS1 permutation switch.
- Sits directly upstream of the crossbar.
- Alternates GUARD (reconfiguration, links invalid) and ACTIVE (circuit stable) intervals, advancing the slot id at each GUARD entry.
- Emits slot-boundary notifications for the ToR schedulers.

---
 rtl/ocs_pkg.sv | 20 ++
 rtl/ocs_interval_cnt.sv | 51 +++++
 rtl/ocs_slot_ctrl.sv | 134 +++++++++++++
 tb/tb_ocs_slot_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ocs_pkg.sv
// Shared types and defaults for the OCS crossbar and its slot controller.
package ocs_pkg;

  // Crossbar configuration defaults shared with the OCS switch modules
  localparam int unsigned OCS_NUM_SLOTS  = 2;
  localparam int unsigned OCS_SLOT_ID_W  = $clog2(OCS_NUM_SLOTS);
  localparam int unsigned OCS_LEN_W      = 16;
  localparam int unsigned OCS_PRE_NOTIFY = 3;

  // Default interval lengths in cycles
  localparam int unsigned OCS_DEF_SLOT_LEN  = 8;
  localparam int unsigned OCS_DEF_GUARD_LEN = 2;

  typedef enum logic [1:0] {
    StIdle,
    StGuard,
    StActive
  } ocs_state_e;

endpackage

// File: rtl/ocs_interval_cnt.sv
// Interval counter: loads a (clamped) length, counts up from zero and flags the
// last cycle of the interval plus whether the next cycle is the pre-end point.
module ocs_interval_cnt #(
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned PRE_NOTIFY = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_load_len,
  output logic             o_last,
  output logic             o_pre_next
);

  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_cnt_d;
  logic [LEN_W-1:0] w_len_d;
  logic [LEN_W-1:0] w_load_len;
  logic [LEN_W-1:0] w_pre_point;

  // Next count/length; a zero length is treated as one cycle
  always_comb begin
    w_load_len = (i_load_len == '0) ? LEN_W'(1) : i_load_len;
    w_cnt_d    = r_cnt;
    w_len_d    = r_len;
    if (i_load) begin
      w_cnt_d = '0;
      w_len_d = w_load_len;
    end else if (i_en) begin
      w_cnt_d = r_cnt + LEN_W'(1);
    end
    // Short intervals fire the pre-end strobe on their first cycle
    w_pre_point = (w_len_d > LEN_W'(PRE_NOTIFY)) ? (w_len_d - LEN_W'(PRE_NOTIFY)) : '0;
    o_pre_next  = (w_cnt_d == w_pre_point);
    o_last      = (r_cnt == (r_len - LEN_W'(1)));
  end

  // Counter and latched length registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_len <= LEN_W'(1);
    end else begin
      r_cnt <= w_cnt_d;
      r_len <= w_len_d;
    end
  end

endmodule

// File: rtl/ocs_slot_ctrl.sv
// Slot schedule generator: alternates GUARD and ACTIVE intervals, advancing the
// crossbar slot id at each GUARD entry and counting full rotations.
module ocs_slot_ctrl
  import ocs_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = OCS_NUM_SLOTS,
  parameter int unsigned SLOT_ID_W  = OCS_SLOT_ID_W,
  parameter int unsigned LEN_W      = OCS_LEN_W,
  parameter int unsigned PRE_NOTIFY = OCS_PRE_NOTIFY
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic [LEN_W-1:0]     i_slot_len,
  input  logic [LEN_W-1:0]     i_guard_len,
  output logic [SLOT_ID_W-1:0] o_slot_id,
  output logic                 o_guard,
  output logic                 o_slot_start,
  output logic                 o_pre_end,
  output logic [31:0]          o_epoch_cnt
);

  ocs_state_e           r_state, w_state_d;
  logic [SLOT_ID_W-1:0] r_slot_id, w_slot_id_d;
  logic [LEN_W-1:0]     r_slot_len, w_slot_len_d;
  logic [31:0]          r_epoch, w_epoch_d;
  logic                 r_guard, w_guard_d;
  logic                 r_slot_start, w_slot_start_d;
  logic                 r_pre_end, w_pre_end_d;
  logic                 w_load;
  logic [LEN_W-1:0]     w_load_len;
  logic                 w_last;
  logic                 w_pre_next;

  ocs_interval_cnt #(
    .LEN_W      (LEN_W),
    .PRE_NOTIFY (PRE_NOTIFY)
  ) u_interval_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (r_state != StIdle),
    .i_load     (w_load),
    .i_load_len (w_load_len),
    .o_last     (w_last),
    .o_pre_next (w_pre_next)
  );

  // Next-state, interval reloads and registered-output next values
  always_comb begin
    w_state_d      = r_state;
    w_slot_id_d    = r_slot_id;
    w_slot_len_d   = r_slot_len;
    w_epoch_d      = r_epoch;
    w_slot_start_d = 1'b0;
    w_load         = 1'b0;
    w_load_len     = r_slot_len;
    unique case (r_state)
      StIdle: begin
        if (i_enable) begin
          w_state_d    = StGuard;
          w_load       = 1'b1;
          w_load_len   = i_guard_len;
          w_slot_len_d = i_slot_len;
          w_slot_id_d  = '0;
        end
      end
      StGuard: begin
        if (w_last) begin
          w_load = 1'b1;
          if (i_enable) begin
            w_state_d      = StActive;
            w_load_len     = r_slot_len;
            w_slot_start_d = 1'b1;
          end else begin
            w_state_d  = StIdle;
            w_load_len = '0;
          end
        end
      end
      StActive: begin
        if (w_last) begin
          w_load = 1'b1;
          if (i_enable) begin
            w_state_d    = StGuard;
            w_load_len   = i_guard_len;
            w_slot_len_d = i_slot_len;
            if (r_slot_id == SLOT_ID_W'(NUM_SLOTS - 1)) begin
              w_slot_id_d = '0;
              w_epoch_d   = r_epoch + 32'd1;
            end else begin
              w_slot_id_d = r_slot_id + SLOT_ID_W'(1);
            end
          end else begin
            w_state_d  = StIdle;
            w_load_len = '0;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    w_guard_d   = (w_state_d != StActive);
    w_pre_end_d = (w_state_d == StActive) && w_pre_next;
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_slot_id    <= '0;
      r_slot_len   <= '0;
      r_epoch      <= '0;
      r_guard      <= 1'b1;
      r_slot_start <= 1'b0;
      r_pre_end    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_slot_id    <= w_slot_id_d;
      r_slot_len   <= w_slot_len_d;
      r_epoch      <= w_epoch_d;
      r_guard      <= w_guard_d;
      r_slot_start <= w_slot_start_d;
      r_pre_end    <= w_pre_end_d;
    end
  end

  assign o_slot_id    = r_slot_id;
  assign o_guard      = r_guard;
  assign o_slot_start = r_slot_start;
  assign o_pre_end    = r_pre_end;
  assign o_epoch_cnt  = r_epoch;

endmodule

// File: tb/tb_ocs_slot_ctrl.sv
// Bench for ocs_slot_ctrl: a remaining-cycles schedule model checked every
// cycle, plus literal expectations at hand-computed cycles.
module tb_ocs_slot_ctrl;

  localparam int unsigned NUM_SLOTS  = 2;
  localparam int unsigned SLOT_ID_W  = 1;
  localparam int unsigned LEN_W      = 16;
  localparam int unsigned PRE_NOTIFY = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic [LEN_W-1:0]     slen;
  logic [LEN_W-1:0]     glen;
  logic [SLOT_ID_W-1:0] slot_id;
  logic                 guard;
  logic                 slot_start;
  logic                 pre_end;
  logic [31:0]          epoch;

  int total = 0;
  int bad   = 0;

  ocs_slot_ctrl #(
    .NUM_SLOTS  (NUM_SLOTS),
    .SLOT_ID_W  (SLOT_ID_W),
    .LEN_W      (LEN_W),
    .PRE_NOTIFY (PRE_NOTIFY)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (en),
    .i_slot_len   (slen),
    .i_guard_len  (glen),
    .o_slot_id    (slot_id),
    .o_guard      (guard),
    .o_slot_start (slot_start),
    .o_pre_end    (pre_end),
    .o_epoch_cnt  (epoch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0=idle 1=guard 2=active; m_left = cycles left incl. current
  int          m_phase = 0;
  int          m_left  = 0;
  int          m_slen  = 1;
  int          m_id    = 0;
  int unsigned m_epoch = 0;
  bit          m_start = 1'b0;
  bit          m_pre   = 1'b0;

  function automatic int clamp1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_id = 0; m_epoch = 0; m_start = 1'b0; m_pre = 1'b0;
    end else begin
      m_start = 1'b0;
      case (m_phase)
        0: if (en) begin
          m_phase = 1; m_id = 0;
          m_left = clamp1(int'(glen)); m_slen = clamp1(int'(slen));
        end
        1: if (m_left == 1) begin
          if (en) begin m_phase = 2; m_left = m_slen; m_start = 1'b1; end
          else m_phase = 0;
        end else m_left--;
        default: if (m_left == 1) begin
          if (en) begin
            m_phase = 1;
            m_left = clamp1(int'(glen)); m_slen = clamp1(int'(slen));
            m_id = (m_id + 1) % NUM_SLOTS;
            if (m_id == 0) m_epoch++;
          end else m_phase = 0;
        end else m_left--;
      endcase
      m_pre = (m_phase == 2) &&
              (m_left == ((m_slen < int'(PRE_NOTIFY)) ? m_slen : int'(PRE_NOTIFY)));
    end
  end

  // Per-cycle compare against the model
  initial forever begin
    @(posedge clk);
    #1;
    chk("m_guard", 32'(guard), (m_phase != 2) ? 32'd1 : 32'd0);
    chk("m_slot_id", 32'(slot_id), 32'(m_id));
    chk("m_slot_start", 32'(slot_start), 32'(m_start));
    chk("m_pre_end", 32'(pre_end), 32'(m_pre));
    chk("m_epoch", epoch, m_epoch);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    en = 1'b0; slen = 16'd8; glen = 16'd2; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_guard", 32'(guard), 1);
    chk("rst_slot_id", 32'(slot_id), 0);
    chk("rst_start", 32'(slot_start), 0);
    chk("rst_pre", 32'(pre_end), 0);
    chk("rst_epoch", epoch, 0);
    rst_n = 1'b1;
    repeat (20) step();
    chk("idle_guard", 32'(guard), 1);
    chk("idle_slot_id", 32'(slot_id), 0);

    // Basic schedule: enable sampled at edge 0, cycle c is after edge c-1
    en = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      case (c)
        1:  chk("basic_guard_c1", 32'(guard), 1);
        3:  begin
          chk("basic_start_c3", 32'(slot_start), 1);
          chk("basic_guard_c3", 32'(guard), 0);
        end
        7:  chk("basic_pre_c7", 32'(pre_end), 0);
        8:  chk("basic_pre_c8", 32'(pre_end), 1);
        11: begin
          chk("basic_id_c11", 32'(slot_id), 1);
          chk("basic_guard_c11", 32'(guard), 1);
        end
        13: chk("basic_start_c13", 32'(slot_start), 1);
        21: begin
          chk("basic_id_c21", 32'(slot_id), 0);
          chk("basic_epoch_c21", epoch, 1);
        end
        default: ;
      endcase
    end

    // Asynchronous reset mid-ACTIVE, between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("async_guard", 32'(guard), 1);
    chk("async_epoch", epoch, 0);
    chk("async_slot_id", 32'(slot_id), 0);
    step();
    rst_n = 1'b1;

    // Enable drop at cycle 5, reassert in IDLE, then shorten slot_len mid-ACTIVE
    for (int c = 1; c <= 28; c++) begin
      step();
      case (c)
        5:  en = 1'b0;
        10: chk("drop_guard_c10", 32'(guard), 0);
        11: begin
          chk("drop_guard_c11", 32'(guard), 1);
          chk("drop_id_c11", 32'(slot_id), 0);
          en = 1'b1;
        end
        14: begin
          chk("reen_start_c14", 32'(slot_start), 1);
          chk("reen_id_c14", 32'(slot_id), 0);
        end
        16: slen = 16'd4;
        21: chk("cfg_guard_c21", 32'(guard), 0);
        22: begin
          chk("cfg_guard_c22", 32'(guard), 1);
          chk("cfg_id_c22", 32'(slot_id), 1);
        end
        25: chk("cfg_pre_c25", 32'(pre_end), 1);
        27: chk("cfg_guard_c27", 32'(guard), 0);
        28: begin
          chk("cfg_guard_c28", 32'(guard), 1);
          chk("cfg_epoch_c28", epoch, 1);
        end
        default: ;
      endcase
    end

    // Zero lengths: one-cycle intervals
    rst_n = 1'b0;
    step();
    slen = 16'd0; glen = 16'd0; en = 1'b1;
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      case (c)
        1: chk("zero_guard_c1", 32'(guard), 1);
        2: begin
          chk("zero_start_c2", 32'(slot_start), 1);
          chk("zero_pre_c2", 32'(pre_end), 1);
        end
        3: chk("zero_id_c3", 32'(slot_id), 1);
        4: begin
          chk("zero_start_c4", 32'(slot_start), 1);
          chk("zero_pre_c4", 32'(pre_end), 1);
        end
        5: begin
          chk("zero_id_c5", 32'(slot_id), 0);
          chk("zero_epoch_c5", epoch, 1);
        end
        default: ;
      endcase
    end

    // Model-only phases: short slot, longer slot, then stop
    slen = 16'd2; glen = 16'd1;
    repeat (20) step();
    slen = 16'd5; glen = 16'd3;
    repeat (30) step();
    en = 1'b0;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
